omsp_dadd_seq: RTL
==================

Name: omsp_dadd_seq

Overview:
- Nibble-serial decimal (BCD) add sequencer for the ALU DADD path.
- Shares one 4-bit adder with carry-in across all nibbles of an operand, one nibble per clock; applies decimal correction and chains the carry.
- Computes result and flags (C, Z, N), then returns `done` to the execution unit.
- Sits between the frontend/execution-unit start strobe and the ALU result/status mux.

Parameters:
- NUM_NIB, 4, nibbles processed in word mode. Must be even and >= 2. Result width W = 4*NUM_NIB.

Ports:
- mclk  input  1  system clock
- puc_rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle operation request; sampled only in IDLE
- byte_mode  input  1  1 = process nibbles 0..1 only
- op_src  input  W  source operand (BCD)
- op_dst  input  W  destination operand (BCD)
- carry_in  input  1  status C flag used as initial carry
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; result/flags valid
- result  output  W  decimal sum
- carry_out  output  1  final decimal carry
- zero  output  1  active result bits all zero
- negative  output  1  result MSB (bit 7 in byte mode, bit W-1 in word mode)

Behaviour:
- Reset: all outputs 0, FSM = IDLE, nibble index = 0, internal operand/carry registers 0.
- Reset is asynchronous and active-high, as already decided. One clock, mclk; reset port named puc_rst.
- FSM states IDLE, CALC, DONE.
  - IDLE -> CALC on start: latch op_src, op_dst, carry_in and byte_mode; clear result; set index = 0.
  - CALC: one nibble per clock. Last index = 1 (byte) or NUM_NIB-1 (word). CALC -> DONE after the last nibble.
  - DONE: `done` = 1 for exactly one cycle, then -> IDLE.
- Latency: `done` is high in the cycle after N+1 rising edges following start sampling, where N = 2 (byte) or NUM_NIB (word). Word mode with the default parameter = 5 clocks; byte mode = 3 clocks.
- Nibble arithmetic:
  - s = a + b + c, 5-bit, where c is the chained carry.
  - If s > 9: nibble = (s + 6) mod 16, next carry = 1.
  - Otherwise: nibble = s[3:0], next carry = 0.
  - Non-BCD digits follow the same formula; no error is flagged.
- result: a nibble register updates at each CALC edge and is valid only while `done` = 1. It holds its value in IDLE until the next start.
- Byte mode: result bits above bit 7 are 0.
- Flags (carry_out, zero, negative) are registered at the CALC -> DONE transition and held until the next start.
- Overflow is not produced; the execution unit clears V.
- start while busy: ignored; no queuing, latched operands unchanged.
- start in the same cycle as the DONE state: ignored. A new start is accepted only in IDLE.
- Input operand changes after the start edge have no effect.
- puc_rst mid-operation: immediate return to IDLE, no `done` pulse, outputs cleared.

Optional Feature:
- Macro: DADD_BIN_MODE_EN
- Defined:
  - Adds input port `bin_mode` (1 bit), latched with start.
  - bin_mode = 1 bypasses decimal correction: nibble = s[3:0], carry = s[4]. This gives a plain nibble-serial binary add with the same timing and flags.
- Undefined: port absent; decimal correction always applied.

Test Plan:
- Word add: op_dst = 0x1234, op_src = 0x5678, carry_in = 0, start -> `done` after 5 clocks, result = 0x6912, C = 0, Z = 0, N = 0, busy high for 5 cycles.
- Carry ripple: 0x9999 + 0x0001, carry_in = 0 -> result = 0x0000, C = 1, Z = 1, N = 0.
- Byte mode: 0x45 + 0x55, carry_in = 1 -> `done` after 3 clocks, result = 0x0001, C = 1, Z = 0, N = 0.
- Invalid digits: 0x000F + 0x000F, carry_in = 1 -> result = 0x0015, C = 0.
- Start while busy: second start with different operands in CALC ignored -> first result 0x6912 reported, single `done` pulse.
- Reset mid-op: assert puc_rst in the 2nd CALC cycle -> no `done`, all outputs 0 immediately; next start completes normally.

Source files
------------

// File: rtl/omsp_dadd_seq_if.sv
// Handshake and operand/result bundle between the execution unit and the DADD sequencer.
// DADD_BIN_MODE_EN adds the bin_mode request bit.
interface omsp_dadd_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic         byte_mode;
    logic [W-1:0] op_src;
    logic [W-1:0] op_dst;
    logic         carry_in;
`ifdef DADD_BIN_MODE_EN
    logic         bin_mode;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         negative;

    modport slave (
`ifdef DADD_BIN_MODE_EN
        input  bin_mode,
`endif
        input  start, byte_mode, op_src, op_dst, carry_in,
        output busy, done, result, carry_out, zero, negative
    );

    modport master (
`ifdef DADD_BIN_MODE_EN
        output bin_mode,
`endif
        output start, byte_mode, op_src, op_dst, carry_in,
        input  busy, done, result, carry_out, zero, negative
    );
endinterface

// File: rtl/omsp_dadd_seq.sv
// Nibble-serial BCD add sequencer: one shared 4-bit adder, one nibble per clock, flags at the end.
// Optional macro DADD_BIN_MODE_EN enables a binary (uncorrected) add mode.
module omsp_dadd_seq #(
    parameter int NUM_NIB = 4
) (
    input  logic           mclk,
    input  logic           puc_rst,
    omsp_dadd_seq_if.slave bus
);
    localparam int W  = 4 * NUM_NIB;
    localparam int IW = (NUM_NIB > 2) ? $clog2(NUM_NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_src;
    logic [W-1:0]  r_dst;
    logic          r_carry;
    logic          r_byte;
    logic          r_bin;
    logic [W-1:0]  r_result;
    logic          r_busy;
    logic          r_done;
    logic          r_cout;
    logic          r_zero;
    logic          r_neg;

    logic [3:0]    w_a;
    logic [3:0]    w_b;
    logic [4:0]    w_sum;
    logic [3:0]    w_nib;
    logic          w_cout;
    logic [IW-1:0] w_last_idx;
    logic [W-1:0]  w_res_next;
    logic          w_bin_req;

`ifdef DADD_BIN_MODE_EN
    assign w_bin_req = bus.bin_mode;
`else
    assign w_bin_req = 1'b0;
`endif

    assign w_a        = r_src[r_idx*4 +: 4];
    assign w_b        = r_dst[r_idx*4 +: 4];
    assign w_sum      = {1'b0, w_a} + {1'b0, w_b} + {4'd0, r_carry};
    assign w_last_idx = r_byte ? IW'(1) : IW'(NUM_NIB - 1);

    // Decimal correction: sums above 9 wrap by adding 6 and produce a carry.
    always_comb begin
        w_nib  = w_sum[3:0];
        w_cout = 1'b0;
        if (r_bin) begin
            w_cout = w_sum[4];
        end else if (w_sum > 5'd9) begin
            w_nib  = w_sum[3:0] + 4'd6;
            w_cout = 1'b1;
        end
    end

    // Result with the current nibble merged in, so flags see the final value.
    generate
        for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_nib
            assign w_res_next[gi*4 +: 4] = (r_idx == IW'(gi)) ? w_nib : r_result[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_carry  <= 1'b0;
            r_byte   <= 1'b0;
            r_bin    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_src    <= bus.op_src;
                        r_dst    <= bus.op_dst;
                        r_carry  <= bus.carry_in;
                        r_byte   <= bus.byte_mode;
                        r_bin    <= w_bin_req;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_cout   <= 1'b0;
                        r_zero   <= 1'b0;
                        r_neg    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_result <= w_res_next;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + IW'(1);
                    if (r_idx == w_last_idx) begin
                        r_cout  <= w_cout;
                        r_zero  <= (w_res_next == '0);
                        r_neg   <= r_byte ? w_res_next[7] : w_res_next[W-1];
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_cout;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_neg;
endmodule
